// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the MIPS control sequencer
//
// Purpose : state encoding, PC-select codes and default timing parameters
//           used by mips_sequencer.
// Ports   : none (package).
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;

  localparam int ALU_TIMEOUT_DEFAULT = 64;
  localparam int MEM_LAT_DEFAULT     = 2;

endpackage

// File: rtl/mips_seq_counter.sv
// rtl/mips_seq_counter.sv - loadable down-counter with zero flag
//
// Purpose : generic N-cycle timer. Loaded with N-1, it reads zero on the
//           Nth cycle after the load, which is the cycle that must act.
// Ports   : clk, rst_b (async active-low)
//           load, load_val - synchronous load (priority over dec)
//           dec            - decrement enable, saturates at zero
//           zero           - count is zero
module mips_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mips_sequencer.sv
// rtl/mips_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//
// Purpose : sequences IR capture, ALU start/ready handshake, data-memory
//           access of MEM_LAT cycles, register write-back, PC update and a
//           sticky halt (halt instruction or ALU timeout).
// Ports   : clk, rst_b (async active-low)
//           dec_*      - decoded instruction attributes
//           alu_ready  - ALU result valid
//           ir_we, alu_start, mem_write_en, mem_read_en, rd_we, pc_we,
//           pc_sel     - datapath strobes
//           halted, alu_err - sticky status
//           state_dbg  - current state, retired - retired-instruction count
module mips_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT     = MEM_LAT_DEFAULT,
  parameter int ALU_TIMEOUT = ALU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        dec_halt,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_writes_rd,
  input  logic        dec_branch_taken,
  input  logic        dec_jump,
  input  logic        alu_ready,
  output logic        ir_we,
  output logic        alu_start,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic        rd_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        alu_err,
  output logic [2:0]  state_dbg,
  output logic [31:0] retired
);

  localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int TW = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

  seq_state_t state_q, state_d;

  logic       lt_load, lt_store, lt_wr;
  logic [1:0] pcsel_q;
  logic       mem_first;
  logic       mem_zero, tmo_zero;
  logic       ready_fire, mem_access, tmo_expire;

  assign mem_access = dec_load | dec_store;
  assign ready_fire = (state_q == S_EXEC) && alu_ready;
  // alu_ready on the final allowed cycle still wins over the timeout.
  assign tmo_expire = (state_q == S_EXEC) && !alu_ready && tmo_zero;

  mips_seq_counter #(.W(MW)) u_mem_cnt (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (ready_fire && mem_access),
    .load_val (MW'(MEM_LAT - 1)),
    .dec      (state_q == S_MEM),
    .zero     (mem_zero)
  );

  mips_seq_counter #(.W(TW)) u_tmo_cnt (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (state_q == S_DECODE),
    .load_val (TW'(ALU_TIMEOUT - 1)),
    .dec      ((state_q == S_EXEC) && !alu_ready),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (alu_ready) begin
          state_d = mem_access ? S_MEM : S_WB;
        end else if (tmo_zero) begin
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        if (mem_zero) begin
          state_d = lt_load ? S_WB : S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_we        = 1'b0;
    alu_start    = 1'b0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    rd_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PCSEL_SEQ;
    halted       = 1'b0;
    case (state_q)
      // Reset parks the FSM in FETCH; keep the IR quiet while reset is held.
      S_FETCH:  ir_we = rst_b;
      S_DECODE: alu_start = !dec_halt;
      S_MEM: begin
        mem_read_en  = lt_load;
        mem_write_en = lt_store && mem_first;
        if (lt_store && mem_zero) begin
          pc_we  = 1'b1;
          pc_sel = pcsel_q;
        end
      end
      S_WB: begin
        rd_we  = lt_wr;
        pc_we  = 1'b1;
        pc_sel = pcsel_q;
      end
      S_HALT:   halted = 1'b1;
      default:  ;
    endcase
  end

  // Decode attributes are frozen on the ALU-ready cycle so the inst bus may
  // move on during MEM/WB. A load+store encoding is treated as a load.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lt_load   <= 1'b0;
      lt_store  <= 1'b0;
      lt_wr     <= 1'b0;
      pcsel_q   <= PCSEL_SEQ;
      mem_first <= 1'b0;
      alu_err   <= 1'b0;
      retired   <= '0;
    end else begin
      if (ready_fire) begin
        lt_load  <= dec_load;
        lt_store <= dec_store & ~dec_load;
        lt_wr    <= dec_writes_rd;
        pcsel_q  <= dec_jump         ? PCSEL_JMP :
                    dec_branch_taken ? PCSEL_BR  : PCSEL_SEQ;
      end
      mem_first <= ready_fire && mem_access;
      if (tmo_expire) begin
        alu_err <= 1'b1;
      end
      if (pc_we) begin
        retired <= retired + 32'd1;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_sequencer.sv
// tb/tb_mips_sequencer.sv - directed self-checking bench for mips_sequencer
module tb_mips_sequencer;

  logic        clk, rst_b;
  logic        dec_halt, dec_load, dec_store, dec_writes_rd;
  logic        dec_branch_taken, dec_jump, alu_ready;
  logic        ir_we, alu_start, mem_write_en, mem_read_en, rd_we, pc_we;
  logic [1:0]  pc_sel;
  logic        halted, alu_err;
  logic [2:0]  state_dbg;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret  = '0;

  mips_sequencer dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .dec_halt         (dec_halt),
    .dec_load         (dec_load),
    .dec_store        (dec_store),
    .dec_writes_rd    (dec_writes_rd),
    .dec_branch_taken (dec_branch_taken),
    .dec_jump         (dec_jump),
    .alu_ready        (alu_ready),
    .ir_we            (ir_we),
    .alu_start        (alu_start),
    .mem_write_en     (mem_write_en),
    .mem_read_en      (mem_read_en),
    .rd_we            (rd_we),
    .pc_we            (pc_we),
    .pc_sel           (pc_sel),
    .halted           (halted),
    .alu_err          (alu_err),
    .state_dbg        (state_dbg),
    .retired          (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec;
    dec_halt = 0; dec_load = 0; dec_store = 0; dec_writes_rd = 0;
    dec_branch_taken = 0; dec_jump = 0; alu_ready = 0;
  endtask

  task automatic test_reset;
    rst_b = 0;
    clear_dec();
    tick();
    tick();
    n_checks++;
    if ({ir_we, alu_start, mem_write_en, mem_read_en, rd_we, pc_we, pc_sel, halted, alu_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {ir_we, alu_start, mem_write_en, mem_read_en, rd_we, pc_we, pc_sel, halted, alu_err});
    end
    n_checks++;
    if (state_dbg !== 3'd0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: state %0d retired %0d expected 0/0", state_dbg, retired);
    end
    rst_b = 1;
    #1;
    n_checks++;
    if (ir_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ir_we: got %b expected 1", ir_we);
    end
    exp_ret = '0;
  endtask

  task automatic test_rtype;
    int exp_st [7];
    exp_st = '{0, 1, 2, 2, 2, 4, 0};
    clear_dec();
    dec_writes_rd = 1;
    for (int i = 0; i < 7; i++) begin
      alu_ready = (i == 4);
      n_checks++;
      if (state_dbg !== 3'(exp_st[i])) begin
        n_fail++;
        $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state_dbg, exp_st[i]);
      end
      n_checks++;
      if ({ir_we, alu_start, rd_we, pc_we, pc_sel} !==
          {(i == 0 || i == 6), (i == 1), (i == 5), (i == 5), 2'b00}) begin
        n_fail++;
        $display("FAIL rtype_strobes[%0d]: got %b", i, {ir_we, alu_start, rd_we, pc_we, pc_sel});
      end
      if (i < 6) tick();
    end
    alu_ready = 0;
    exp_ret++;
    n_checks++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL rtype_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_load;
    int exp_st [7];
    exp_st = '{0, 1, 2, 3, 3, 4, 0};
    clear_dec();
    dec_load = 1; dec_writes_rd = 1; alu_ready = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        dec_load = 0; dec_writes_rd = 0;
      end
      n_checks++;
      if (state_dbg !== 3'(exp_st[i])) begin
        n_fail++;
        $display("FAIL load_state[%0d]: got %0d expected %0d", i, state_dbg, exp_st[i]);
      end
      n_checks++;
      if ({mem_read_en, mem_write_en, rd_we, pc_we} !== {(i == 3 || i == 4), 1'b0, (i == 5), (i == 5)}) begin
        n_fail++;
        $display("FAIL load_strobes[%0d]: got %b", i, {mem_read_en, mem_write_en, rd_we, pc_we});
      end
      if (i < 6) tick();
    end
    clear_dec();
    exp_ret++;
    n_checks++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL load_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_store;
    int exp_st [6];
    exp_st = '{0, 1, 2, 3, 3, 0};
    clear_dec();
    dec_store = 1; dec_writes_rd = 1; alu_ready = 1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (state_dbg !== 3'(exp_st[i])) begin
        n_fail++;
        $display("FAIL store_state[%0d]: got %0d expected %0d", i, state_dbg, exp_st[i]);
      end
      n_checks++;
      if ({mem_write_en, mem_read_en, rd_we, pc_we, pc_sel} !== {(i == 3), 1'b0, 1'b0, (i == 4), 2'b00}) begin
        n_fail++;
        $display("FAIL store_strobes[%0d]: got %b", i, {mem_write_en, mem_read_en, rd_we, pc_we, pc_sel});
      end
      if (i < 5) tick();
    end
    clear_dec();
    exp_ret++;
    n_checks++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL store_retired: got %0d expected %0d", retired, exp_ret);
    end
  endtask

  task automatic test_branch(input logic jmp, input logic [1:0] exp_sel);
    int exp_st [5];
    exp_st = '{0, 1, 2, 4, 0};
    clear_dec();
    dec_branch_taken = 1; dec_jump = jmp; alu_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        dec_branch_taken = 0; dec_jump = 0;
      end
      n_checks++;
      if (state_dbg !== 3'(exp_st[i])) begin
        n_fail++;
        $display("FAIL branch%0d_state[%0d]: got %0d expected %0d", jmp, i, state_dbg, exp_st[i]);
      end
      n_checks++;
      if ({rd_we, pc_we, pc_sel} !== ((i == 3) ? {1'b0, 1'b1, exp_sel} : 4'b0000)) begin
        n_fail++;
        $display("FAIL branch%0d_pc[%0d]: got %b expected sel %0d", jmp, i, {rd_we, pc_we, pc_sel}, exp_sel);
      end
      if (i < 4) tick();
    end
    clear_dec();
    exp_ret++;
  endtask

  task automatic test_timeout_boundary;
    int bad = 0;
    clear_dec();
    tick();
    tick();
    for (int i = 1; i <= 64; i++) begin
      if (state_dbg !== 3'd2) bad++;
      alu_ready = (i == 64);
      tick();
    end
    alu_ready = 0;
    n_checks++;
    if (bad != 0 || state_dbg !== 3'd4 || alu_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_boundary: bad %0d state %0d alu_err %b expected 0/4/0", bad, state_dbg, alu_err);
    end
    tick();
    exp_ret++;
    n_checks++;
    if (state_dbg !== 3'd0 || retired !== exp_ret) begin
      n_fail++;
      $display("FAIL tmo_boundary_retire: state %0d retired %0d expected 0/%0d", state_dbg, retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_mem;
    clear_dec();
    dec_store = 1; alu_ready = 1;
    tick();
    tick();
    tick();
    n_checks++;
    if (mem_write_en !== 1'b1 || state_dbg !== 3'd3) begin
      n_fail++;
      $display("FAIL midmem_pre: wr %b state %0d expected 1/3", mem_write_en, state_dbg);
    end
    #3 rst_b = 0;
    #1;
    n_checks++;
    if ({mem_write_en, pc_we, state_dbg} !== 5'b0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL midmem_async: wr %b pc_we %b state %0d retired %0d expected 0", mem_write_en, pc_we, state_dbg, retired);
    end
    clear_dec();
    tick();
    rst_b = 1;
    exp_ret = '0;
    #1;
    n_checks++;
    if (state_dbg !== 3'd0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL midmem_release: state %0d retired %0d expected 0/0", state_dbg, retired);
    end
  endtask

  task automatic test_wrap;
    clear_dec();
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    dec_writes_rd = 1; alu_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    clear_dec();
    n_checks++;
    if (state_dbg !== 3'd0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap: state %0d retired %0h expected 0/0", state_dbg, retired);
    end
    exp_ret = '0;
  endtask

  task automatic test_reset_mid_exec;
    clear_dec();
    tick();
    tick();
    tick();
    n_checks++;
    if (state_dbg !== 3'd2 || retired === 32'd0) begin
      n_fail++;
      $display("FAIL midexec_pre: state %0d retired %0d expected 2/nonzero", state_dbg, retired);
    end
    #3 rst_b = 0;
    #1;
    n_checks++;
    if ({ir_we, alu_start, mem_write_en, mem_read_en, rd_we, pc_we, pc_sel, halted, alu_err, state_dbg} !== 13'b0 ||
        retired !== 32'd0) begin
      n_fail++;
      $display("FAIL midexec_async: state %0d retired %0d ir_we %b expected all 0", state_dbg, retired, ir_we);
    end
    tick();
    rst_b = 1;
    exp_ret = '0;
    #1;
    n_checks++;
    if (state_dbg !== 3'd0 || ir_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midexec_release: state %0d ir_we %b expected 0/1", state_dbg, ir_we);
    end
  endtask

  task automatic test_halt_dec;
    int bad = 0;
    clear_dec();
    dec_halt = 1;
    tick();
    n_checks++;
    if (state_dbg !== 3'd1 || alu_start !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_decode: state %0d alu_start %b expected 1/0", state_dbg, alu_start);
    end
    tick();
    dec_halt = 0;
    n_checks++;
    if (state_dbg !== 3'd5 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_enter: state %0d halted %b expected 5/1", state_dbg, halted);
    end
    for (int i = 0; i < 100; i++) begin
      alu_ready = i[0];
      if (halted !== 1'b1 || state_dbg !== 3'd5 ||
          {ir_we, alu_start, mem_write_en, mem_read_en, rd_we, pc_we, pc_sel} !== 8'b0) bad++;
      tick();
    end
    clear_dec();
    n_checks++;
    if (bad != 0 || retired !== exp_ret) begin
      n_fail++;
      $display("FAIL halt_sticky: bad cycles %0d retired %0d expected 0/%0d", bad, retired, exp_ret);
    end
  endtask

  task automatic test_timeout_err;
    int bad = 0;
    clear_dec();
    tick();
    tick();
    for (int i = 1; i <= 64; i++) begin
      if (state_dbg !== 3'd2 || alu_err !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0 || state_dbg !== 3'd5 || alu_err !== 1'b1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_err: bad %0d state %0d alu_err %b halted %b expected 0/5/1/1", bad, state_dbg, alu_err, halted);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch(1'b1, 2'd2);
    test_branch(1'b0, 2'd1);
    test_timeout_boundary();
    test_reset_mid_mem();
    test_wrap();
    test_rtype();
    test_reset_mid_exec();
    test_halt_dec();
    test_reset();
    test_timeout_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_sequencer.md
Name: mips_sequencer

Overview:
- Multi-cycle control sequencer for the MIPS core.
- Replaces free-running PC increment with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Sequences PC update, IR capture, ALU start/ready handshake, data-memory access with configurable latency, register write-back and sticky halt.
- Sits between instruction decode and the regfile/ALU/memory datapath.

Parameters:
- MEM_LAT, 2, data-memory access cycles (>=1) spent in MEM state.
- ALU_TIMEOUT, 64, max EXEC cycles waiting for alu_ready before error halt.

Ports:
- clk  in  1  core clock.
- rst_b  in  1  asynchronous active-low reset.
- dec_halt  in  1  decoded instruction is halt/syscall.
- dec_load  in  1  decoded load.
- dec_store  in  1  decoded store.
- dec_writes_rd  in  1  instruction writes a register.
- dec_branch_taken  in  1  branch condition true (valid in EXEC when alu_ready).
- dec_jump  in  1  jump/jal.
- alu_ready  in  1  ALU result valid.
- ir_we  out  1  capture instruction register.
- alu_start  out  1  one-cycle ALU start pulse.
- mem_write_en  out  1  data-memory write strobe.
- mem_read_en  out  1  data-memory read enable.
- rd_we  out  1  regfile write enable.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  0 = pc+4, 1 = branch target, 2 = jump target.
- halted  out  1  sticky halt.
- alu_err  out  1  sticky ALU-timeout flag.
- state_dbg  out  3  current state encoding.
- retired  out  32  retired-instruction counter.

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (rst_b low, async): state=FETCH, all strobes 0, pc_sel=0, halted=0, alu_err=0, retired=0, internal counters 0.
- FETCH: ir_we=1 for exactly one cycle -> DECODE.
- DECODE:
  - dec_halt -> HALT.
  - else alu_start=1 for this cycle, clear timeout counter -> EXEC.
- EXEC: hold until alu_ready=1.
  - On the ready cycle, latch branch_taken/jump into a pc_sel register. Jump has priority over branch.
  - dec_load or dec_store -> MEM with latency counter = MEM_LAT-1.
  - otherwise -> WB.
  - Timeout counter increments each non-ready cycle. Reaching ALU_TIMEOUT sets alu_err=1 and goes to HALT.
- MEM:
  - Store: mem_write_en=1 only on the first MEM cycle.
  - Load: mem_read_en=1 on every MEM cycle.
  - Counter decrements each cycle; at 0, load -> WB, store -> FETCH.
  - On the store's final MEM cycle, pc_we=1 and retired increments.
- WB (one cycle): rd_we=dec_writes_rd, pc_we=1, pc_sel=latched value, retired += 1 -> FETCH.
- HALT: absorbing; halted=1, all strobes 0. Only reset exits.
- retired: wraps at 2^32-1 -> 0.
- pc_sel outputs 0 outside pc_we cycles.
- Strobes are Moore outputs from registered state, except rd_we, pc_sel and mem_write_en, which may use registered decode latches.
- Decode inputs are sampled in DECODE/EXEC and held in flops, so a change on the inst bus after EXEC does not affect MEM/WB.
- Simultaneous alu_ready and timeout threshold: alu_ready wins, no error.
- Reset mid-MEM store: write strobe drops asynchronously, no retired increment.
- MEM_LAT=1: MEM lasts exactly one cycle. Store write and pc_we occur in that same cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum seq_state_t (3-bit);
  - pc_sel constants PCSEL_SEQ/PCSEL_BR/PCSEL_JMP;
  - ALU_TIMEOUT default.
- Sub-module mips_seq_counter: generic loadable down-counter with zero flag. It is reused for the MEM latency and the ALU timeout (up-count via load of ALU_TIMEOUT).

Test Plan:
- R-type, dec_writes_rd=1, alu_ready 3 cycles after alu_start:
  - state path 0,1,2,2,2,4,0;
  - rd_we=1 and pc_we=1 with pc_sel=0 in the WB cycle;
  - retired=1.
- Load, MEM_LAT=2, alu_ready immediate:
  - mem_read_en high 2 cycles, then WB with rd_we=1;
  - total 6 cycles FETCH-to-FETCH.
- Store, MEM_LAT=2:
  - mem_write_en high exactly 1 cycle (first MEM);
  - pc_we on second MEM cycle, rd_we never asserted.
- Branch taken with dec_jump=1 simultaneously -> pc_sel=2 on the WB pc_we cycle. With branch only -> pc_sel=1.
- Halt paths:
  - dec_halt in DECODE -> halted=1 next cycle; stays high 100 cycles with all strobes 0.
  - alu_ready held 0 for 64 cycles -> alu_err=1, halted=1.
- Reset cases:
  - rst_b pulled low mid-EXEC, asynchronous to clk: outputs 0 immediately; after release, state=FETCH and retired=0.
  - retired preset via 2^32-1 retirements (forced) -> wraps to 0.
